// File: rtl/core_pkg.sv
// Shared core types: PC source classes, trap PC selection,
// mtvec modes and redirect source encoding.
package core_pkg;

  typedef enum logic [1:0] {
    PC_NONE   = 2'b00,
    PC_JAL    = 2'b01,
    PC_JALR   = 2'b10,
    PC_BRANCH = 2'b11
  } pc_source_t;

  typedef enum logic [1:0] {
    EXC_PC_EXC  = 2'b00,
    EXC_PC_IRQ  = 2'b01,
    EXC_PC_MRET = 2'b10
  } exc_pc_mux_t;

  typedef enum logic [1:0] {
    MTVEC_DIRECT   = 2'b00,
    MTVEC_VECTORED = 2'b01
  } mtvec_mode_t;

  typedef enum logic [2:0] {
    RD_NONE    = 3'd0,
    RD_TRAP_EX = 3'd1,
    RD_BRANCH  = 3'd2,
    RD_TRAP_ID = 3'd3,
    RD_JUMP    = 3'd4
  } redirect_src_t;

endpackage

// File: rtl/trap_target_gen.sv
// Trap target: MRET returns to mepc, otherwise mtvec base,
// offset by cause*4 for vectored interrupts.
module trap_target_gen
  import core_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] mtvec_i,
  input  logic [WIDTH-1:0] mepc_i,
  input  logic             is_mret_i,
  input  logic             trap_is_irq_i,
  input  logic [4:0]       trap_cause_i,
  output logic [WIDTH-1:0] trap_tgt_o
);

  exc_pc_mux_t      sel;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] vec;

  assign base = {mtvec_i[WIDTH-1:2], 2'b00};
  assign vec  = base + {{(WIDTH-7){1'b0}}, trap_cause_i, 2'b00};

  // Reserved modes 10/11 fall through to direct
  always_comb begin
    sel = EXC_PC_EXC;
    if (is_mret_i)
      sel = EXC_PC_MRET;
    else if (trap_is_irq_i && mtvec_i[1:0] == MTVEC_VECTORED)
      sel = EXC_PC_IRQ;
  end

  always_comb begin
    trap_tgt_o = base;
    unique case (sel)
      EXC_PC_MRET: trap_tgt_o = mepc_i;
      EXC_PC_IRQ:  trap_tgt_o = vec;
      default:     trap_tgt_o = base;
    endcase
  end

endmodule

// File: rtl/pc_gen.sv
// Registered PC generator: owns the PC, offers it to fetch over
// valid/ready and holds redirects that arrive while fetch stalls.
module pc_gen
  import core_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] BOOT_ADDR = 32'h0000_0080
) (
  input  logic             clk_i,
  input  logic             rst_i,
  output logic [WIDTH-1:0] pc_o,
  output logic             fetch_valid_o,
  input  logic             fetch_ready_i,
  input  logic             is_compressed_i,
  input  logic             core_ready_i,
  input  logic             valid_id_i,
  input  logic             valid_ex_i,
  input  pc_source_t       pc_source_id_i,
  input  pc_source_t       pc_source_ex_i,
  input  logic [WIDTH-1:0] jump_target_id_i,
  input  logic [WIDTH-1:0] branch_target_ex_i,
  input  logic             branch_decision_ex_i,
  input  logic             trap_id_i,
  input  logic             trap_ex_i,
  input  logic             is_mret_i,
  input  logic             trap_is_irq_i,
  input  logic [4:0]       trap_cause_i,
  input  logic [WIDTH-1:0] mtvec_i,
  input  logic [WIDTH-1:0] mepc_i,
  output logic             redirect_o
);

  localparam logic [WIDTH-1:0] INC2 = WIDTH'(2);
  localparam logic [WIDTH-1:0] INC4 = WIDTH'(4);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             valid_q;
  logic             pend_q, pend_d;
  logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;

  redirect_src_t    src;
  logic [WIDTH-1:0] trap_tgt;
  logic [WIDTH-1:0] tgt_raw;
  logic [WIDTH-1:0] tgt;
  logic             hit;
  logic             accept;
  logic             tex, br, tid, jmp;

  trap_target_gen #(
    .WIDTH(WIDTH)
  ) u_trap (
    .mtvec_i      (mtvec_i),
    .mepc_i       (mepc_i),
    .is_mret_i    (is_mret_i),
    .trap_is_irq_i(trap_is_irq_i),
    .trap_cause_i (trap_cause_i),
    .trap_tgt_o   (trap_tgt)
  );

  assign tex = valid_ex_i & trap_ex_i;
  assign br  = valid_ex_i & branch_decision_ex_i
             & (pc_source_ex_i == PC_BRANCH);
  assign tid = valid_id_i & trap_id_i;
  assign jmp = valid_id_i & ((pc_source_id_i == PC_JAL)
             | (pc_source_id_i == PC_JALR));

  always_comb begin
    src = RD_NONE;
    if (core_ready_i && !rst_i) begin
      if (tex)      src = RD_TRAP_EX;
      else if (br)  src = RD_BRANCH;
      else if (tid) src = RD_TRAP_ID;
      else if (jmp) src = RD_JUMP;
    end
  end

  always_comb begin
    tgt_raw = trap_tgt;
    unique case (src)
      RD_BRANCH: tgt_raw = branch_target_ex_i;
      RD_JUMP:   tgt_raw = jump_target_id_i;
      default:   tgt_raw = trap_tgt;
    endcase
  end

  assign tgt        = {tgt_raw[WIDTH-1:1], 1'b0};
  assign hit        = (src != RD_NONE);
  assign accept     = valid_q & fetch_ready_i;
  assign redirect_o = hit;

  always_comb begin
    pc_d       = pc_q;
    pend_d     = pend_q;
    pend_tgt_d = pend_tgt_q;
    if (accept) begin
      pend_d = 1'b0;
      if (hit)
        pc_d = tgt;
      else if (pend_q)
        pc_d = pend_tgt_q;
      else
        pc_d = pc_q + (is_compressed_i ? INC2 : INC4);
    end else if (hit) begin
      // Newest redirect replaces any older pending one
      pend_d     = 1'b1;
      pend_tgt_d = tgt;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q       <= BOOT_ADDR;
      valid_q    <= 1'b0;
      pend_q     <= 1'b0;
      pend_tgt_q <= BOOT_ADDR;
    end else begin
      pc_q       <= pc_d;
      valid_q    <= 1'b1;
      pend_q     <= pend_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  assign pc_o          = pc_q;
  assign fetch_valid_o = valid_q;

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed scenarios plus randomized run
// against a behavioural next-PC model.
module tb_pc_gen;
  import core_pkg::*;

  localparam logic [31:0] BOOT = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        fvalid;
  logic        ready;
  logic        comp;
  logic        core_ready;
  logic        valid_id, valid_ex;
  pc_source_t  src_id, src_ex;
  logic [31:0] jtgt, btgt;
  logic        bdec;
  logic        trap_id, trap_ex;
  logic        mret, irq;
  logic [4:0]  cause;
  logic [31:0] mtvec, mepc;
  logic        redir;

  int total = 0;
  int bad   = 0;

  logic [31:0] m_pc;
  logic        m_valid;
  logic        m_pend;
  logic [31:0] m_ptgt;

  pc_gen #(.WIDTH(32), .BOOT_ADDR(BOOT)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .pc_o                (pc),
    .fetch_valid_o       (fvalid),
    .fetch_ready_i       (ready),
    .is_compressed_i     (comp),
    .core_ready_i        (core_ready),
    .valid_id_i          (valid_id),
    .valid_ex_i          (valid_ex),
    .pc_source_id_i      (src_id),
    .pc_source_ex_i      (src_ex),
    .jump_target_id_i    (jtgt),
    .branch_target_ex_i  (btgt),
    .branch_decision_ex_i(bdec),
    .trap_id_i           (trap_id),
    .trap_ex_i           (trap_ex),
    .is_mret_i           (mret),
    .trap_is_irq_i       (irq),
    .trap_cause_i        (cause),
    .mtvec_i             (mtvec),
    .mepc_i              (mepc),
    .redirect_o          (redir)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_trap();
    logic [31:0] base;
    if (mret) return mepc;
    base = mtvec - (mtvec % 4);
    if (irq && (mtvec % 4) == 1) return base + 4 * cause;
    return base;
  endfunction

  function automatic bit ref_redirect(output logic [31:0] t);
    t = 32'h0;
    if (rst || !core_ready) return 1'b0;
    if (valid_ex && trap_ex) t = ref_trap();
    else if (valid_ex && src_ex == PC_BRANCH && bdec) t = btgt;
    else if (valid_id && trap_id) t = ref_trap();
    else if (valid_id && (src_id == PC_JAL || src_id == PC_JALR)) t = jtgt;
    else return 1'b0;
    t = t & ~32'h1;
    return 1'b1;
  endfunction

  task automatic tick();
    logic [31:0] t;
    bit h;
    h = ref_redirect(t);
    if (rst) begin
      m_pc = BOOT; m_valid = 0; m_pend = 0;
    end else begin
      if (m_valid && ready) begin
        if (h) m_pc = t;
        else if (m_pend) m_pc = m_ptgt;
        else m_pc = m_pc + (comp ? 2 : 4);
        m_pend = 0;
      end else if (h) begin
        m_pend = 1; m_ptgt = t;
      end
      m_valid = 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ready = 1; comp = 0; core_ready = 1;
    valid_id = 0; valid_ex = 0;
    src_id = PC_NONE; src_ex = PC_NONE;
    jtgt = 0; btgt = 0; bdec = 0;
    trap_id = 0; trap_ex = 0; mret = 0; irq = 0;
    cause = 0; mtvec = 0; mepc = 0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1;
    trap_ex = 1; valid_ex = 1;
    for (int i = 0; i < 3; i++) tick();
    total++;
    if (pc !== BOOT) begin
      bad++; $display("FAIL reset_pc got=%h exp=%h", pc, BOOT);
    end
    total++;
    if (fvalid !== 1'b0) begin
      bad++; $display("FAIL reset_valid got=%b exp=0", fvalid);
    end
    total++;
    if (redir !== 1'b0) begin
      bad++; $display("FAIL reset_redirect got=%b exp=0", redir);
    end
    idle();
    rst = 0;
    tick();
    total++;
    if (fvalid !== 1'b1 || pc !== BOOT) begin
      bad++;
      $display("FAIL release got=%b/%h exp=1/%h", fvalid, pc, BOOT);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp [3];
    logic        cp  [3];
    exp[0] = 32'h84; exp[1] = 32'h86; exp[2] = 32'h8A;
    cp[0] = 0; cp[1] = 1; cp[2] = 0;
    idle();
    for (int i = 0; i < 3; i++) begin
      comp = cp[i];
      tick();
      total++;
      if (pc !== exp[i]) begin
        bad++; $display("FAIL seq%0d got=%h exp=%h", i, pc, exp[i]);
      end
    end
  endtask

  task automatic test_priority();
    idle();
    valid_ex = 1; valid_id = 1;
    trap_ex = 1;
    src_ex = PC_BRANCH; bdec = 1; btgt = 32'h400;
    src_id = PC_JAL; jtgt = 32'h500;
    mtvec = 32'h100;
    #1;
    total++;
    if (redir !== 1'b1) begin
      bad++; $display("FAIL prio_redirect got=%b exp=1", redir);
    end
    tick();
    total++;
    if (pc !== 32'h100) begin
      bad++; $display("FAIL prio_pc got=%h exp=00000100", pc);
    end
  endtask

  task automatic test_vectored();
    logic [31:0] exp [3];
    exp[0] = 32'h21C; exp[1] = 32'h200; exp[2] = 32'h3A4;
    for (int i = 0; i < 3; i++) begin
      idle();
      valid_ex = 1; trap_ex = 1;
      mtvec = 32'h201; mepc = 32'h3A4;
      irq   = (i == 0);
      cause = (i == 0) ? 5'd7 : 5'd2;
      mret  = (i == 2);
      tick();
      total++;
      if (pc !== exp[i]) begin
        bad++; $display("FAIL vec%0d got=%h exp=%h", i, pc, exp[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] held;
    idle();
    held = pc;
    ready = 0;
    valid_ex = 1; src_ex = PC_BRANCH; bdec = 1; btgt = 32'h400;
    tick();
    total++;
    if (pc !== held) begin
      bad++; $display("FAIL stall_hold got=%h exp=%h", pc, held);
    end
    idle();
    ready = 0;
    valid_id = 1; src_id = PC_JAL; jtgt = 32'h500;
    tick();
    total++;
    if (pc !== held) begin
      bad++; $display("FAIL stall_hold2 got=%h exp=%h", pc, held);
    end
    idle();
    tick();
    total++;
    if (pc !== 32'h500) begin
      bad++; $display("FAIL stall_release got=%h exp=00000500", pc);
    end
    idle();
    ready = 0;
    valid_ex = 1; src_ex = PC_BRANCH; bdec = 1; btgt = 32'h600;
    tick();
    idle();
    ready = 0;
    rst = 1;
    tick();
    rst = 0;
    tick();
    total++;
    if (pc !== BOOT || fvalid !== 1'b1) begin
      bad++;
      $display("FAIL stall_reset got=%h/%b exp=%h/1", pc, fvalid, BOOT);
    end
    ready = 1;
    tick();
    total++;
    if (pc !== 32'h84) begin
      bad++; $display("FAIL stall_nopend got=%h exp=00000084", pc);
    end
  endtask

  task automatic test_wrap_gate();
    idle();
    valid_id = 1; src_id = PC_JALR; jtgt = 32'hFFFF_FFFD;
    tick();
    total++;
    if (pc !== 32'hFFFF_FFFC) begin
      bad++; $display("FAIL align got=%h exp=fffffffc", pc);
    end
    idle();
    tick();
    total++;
    if (pc !== 32'h0) begin
      bad++; $display("FAIL wrap got=%h exp=00000000", pc);
    end
    idle();
    core_ready = 0;
    valid_id = 1; src_id = PC_JAL; jtgt = 32'h500;
    #1;
    total++;
    if (redir !== 1'b0) begin
      bad++; $display("FAIL gate_redirect got=%b exp=0", redir);
    end
    tick();
    total++;
    if (pc !== 32'h4) begin
      bad++; $display("FAIL gate_pc got=%h exp=00000004", pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] t;
    bit h;
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 49) == 0);
      ready      = ($urandom_range(0, 9) < 6);
      comp       = $urandom_range(0, 1);
      core_ready = ($urandom_range(0, 9) < 8);
      valid_id   = $urandom_range(0, 1);
      valid_ex   = $urandom_range(0, 1);
      src_id     = pc_source_t'($urandom_range(0, 3));
      src_ex     = pc_source_t'($urandom_range(0, 3));
      jtgt       = $urandom;
      btgt       = $urandom;
      bdec       = $urandom_range(0, 1);
      trap_id    = ($urandom_range(0, 7) == 0);
      trap_ex    = ($urandom_range(0, 7) == 0);
      mret       = ($urandom_range(0, 3) == 0);
      irq        = $urandom_range(0, 1);
      cause      = 5'($urandom);
      mtvec      = $urandom;
      mepc       = $urandom;
      #1;
      h = ref_redirect(t);
      total++;
      if (redir !== h) begin
        bad++; $display("FAIL rnd_redirect n=%0d got=%b exp=%b", n, redir, h);
      end
      tick();
      total++;
      if (pc !== m_pc || fvalid !== m_valid) begin
        bad++;
        $display("FAIL rnd_state n=%0d got=%h/%b exp=%h/%b",
                 n, pc, fvalid, m_pc, m_valid);
      end
    end
    rst = 0;
  endtask

  initial begin
    m_pc = BOOT; m_valid = 0; m_pend = 0; m_ptgt = BOOT;
    idle();
    rst = 1;
    @(posedge clk);
    #1;
    test_reset();
    test_sequential();
    test_priority();
    test_vectored();
    test_stall();
    test_wrap_gate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
# pc_gen

Registered program-counter generator for the RISC-X front end. It supersedes the purely combinational next-PC selection with a stateful block that:
- owns the PC register and its boot address;
- presents the PC to fetch over a valid/ready handshake;
- adds 2 or 4 depending on compressed instructions;
- computes direct or vectored `mtvec` trap targets;
- holds a redirect that arrives while fetch is stalled until fetch can consume it.

It sits between the ID/EX redirect sources and the instruction-fetch stage.

## Interface
Parameters:
- `WIDTH`, 32: address width.
- `BOOT_ADDR`, `32'h0000_0080`: PC value held during reset and presented first.

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: reset. Synchronous, active-high.
- `pc_o` out WIDTH: PC offered to fetch.
- `fetch_valid_o` out 1: `pc_o` is valid.
- `fetch_ready_i` in 1: fetch accepts `pc_o` this cycle.
- `is_compressed_i` in 1: the instruction at the accepted `pc_o` is 16-bit. Sampled only on acceptance.
- `core_ready_i` in 1: 0 means redirect inputs are ignored this cycle.
- `valid_id_i`, `valid_ex_i` in 1: stage-valid qualifiers.
- `pc_source_id_i`, `pc_source_ex_i` in `pc_source_t`: jump/branch class per stage.
- `jump_target_id_i` in WIDTH: JAL/JALR target from ID.
- `branch_target_ex_i` in WIDTH, `branch_decision_ex_i` in 1: EX branch target and taken flag.
- `trap_id_i`, `trap_ex_i` in 1: trap request per stage.
- `is_mret_i` in 1: the trap is an MRET.
- `trap_is_irq_i` in 1, `trap_cause_i` in 5: interrupt flag and cause code.
- `mtvec_i`, `mepc_i` in WIDTH: CSR values.
- `redirect_o` out 1: one-cycle pulse when a redirect is sampled, for flush logic.

## Operation
- **Redirect request.** Qualify each source with its stage valid, then pick the highest-priority one:
  1. `trap_ex_i`
  2. EX `PC_BRANCH` with `branch_decision_ex_i` set
  3. `trap_id_i`
  4. ID `PC_JAL`/`PC_JALR`
  - A request is sampled only when `core_ready_i`=1.
- **Trap target.**
  - `is_mret_i` → `mepc_i`.
  - Otherwise base = {`mtvec_i[WIDTH-1:2]`, 2'b00}.
  - Mode `mtvec_i[1:0]`=01 and `trap_is_irq_i` → base + (`trap_cause_i` << 2).
  - All other cases → base. Modes 10/11 are treated as direct.
- **Alignment.** Bit 0 of every redirect target is forced to 0.
- **State.**
  - `pc_q`.
  - `valid_q`.
  - `pend_q` and `pend_tgt_q`: a latched redirect.
- **On acceptance** (`fetch_valid_o && fetch_ready_i`), next `pc_q` is, in priority order:
  1. the current-cycle redirect target;
  2. else `pend_tgt_q` if `pend_q` is set;
  3. else `pc_q` + 2 (`is_compressed_i`=1) or + 4.
  - `pend_q` clears on acceptance.
- **Without acceptance:**
  - `pc_o` stays stable while `fetch_valid_o`=1 (handshake rule).
  - A sampled redirect is written into `pend_tgt_q` and sets `pend_q`.
  - A later redirect overwrites an existing pending one (newest wins).
- **Arithmetic.** Increment wraps modulo 2^WIDTH.
- **Reset.** While `rst_i`=1:
  - `pc_o`=`BOOT_ADDR`, `fetch_valid_o`=0, `redirect_o`=0;
  - `pend_q` is cleared.
  - Reset asserted mid-stall discards any pending redirect.

## Timing
- `pc_o`, `fetch_valid_o` and `pend_q` are registered. `redirect_o` is combinational from the sampled request.
- `fetch_valid_o` rises in the first cycle after `rst_i` falls and stays 1 until the next reset.
- Redirect with `fetch_ready_i`=1 in cycle N → `pc_o` = target in cycle N+1.
- Redirect while stalled → target appears on `pc_o` in the cycle after the next acceptance. The instruction accepted in between is squashed by the pipeline via `redirect_o`.
- Redirect and acceptance in the same cycle as a set `pend_q` → the current redirect wins and `pend_q` clears.
- `core_ready_i`=0 → redirect inputs ignored and `redirect_o`=0. The sequential handshake still advances.

## Structure
- `core_pkg` additions:
  - `mtvec_mode_t` with `MTVEC_DIRECT`=2'b00 and `MTVEC_VECTORED`=2'b01;
  - a `redirect_src_t` enum (`RD_NONE`, `RD_TRAP_EX`, `RD_BRANCH`, `RD_TRAP_ID`, `RD_JUMP`).
- Reuse the existing `pc_source_t` and `exc_pc_mux_t`.
- One combinational sub-module, `trap_target_gen`, produces the trap target from `mtvec_i`, `mepc_i`, `is_mret_i`, `trap_is_irq_i` and `trap_cause_i`.

## Test plan
- **Reset.** `rst_i`=1 for 3 cycles with `BOOT_ADDR`=0x80 → `pc_o`=0x80 and `fetch_valid_o`=0. First cycle after release → `fetch_valid_o`=1.
- **Sequential.** Ready held at 1, compressed pattern 0,1,0 → `pc_o` sequence 0x80, 0x84, 0x86, 0x8A.
- **Priority.** `trap_ex_i`, taken branch (0x400) and JAL (0x500) in the same cycle, `mtvec_i`=0x100 → `pc_o`=0x100 next cycle and `redirect_o`=1.
- **Vectored trap targets**, `mtvec_i`=0x201:
  - irq cause 7 → 0x21C;
  - exception cause 2 → 0x200;
  - MRET with `mepc_i`=0x3A4 → 0x3A4.
- **Stall.**
  - `fetch_ready_i`=0, branch to 0x400 → `pc_o` is unchanged.
  - Then JAL to 0x500 while still stalled → pending target is overwritten.
  - Accept → `pc_o`=0x500.
  - Reset during a stall → 0x80 with no pending redirect.
- **Wrap and gating.**
  - `pc_q`=0xFFFF_FFFC, non-compressed accept → 0x0000_0000.
  - JAL with `core_ready_i`=0 → ignored, `redirect_o`=0.
